// File: rtl/best_array_streamer_pkg.sv
// Shared types for the ANN accelerator output streamer: word width, stream
// modes, FSM state encoding and the per-pass word-selection helper.
package ann_pkg;

  localparam int DATA_WIDTH = 11;

  typedef enum logic [1:0] {
    MODE_SPLIT      = 2'b00,  // all indices, then all distances
    MODE_IDX        = 2'b01,  // indices only
    MODE_DIST       = 2'b10,  // distances only
    MODE_INTERLEAVE = 2'b11   // index followed by its distance words
  } stream_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CAPT = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4
  } stream_state_e;

  // Returns {send_idx, send_dist} for a pass of the given mode.
  function automatic logic [1:0] pass_flags(input stream_mode_e m, input logic second_pass);
    logic [1:0] flags;
    case (m)
      MODE_SPLIT:      flags = second_pass ? 2'b01 : 2'b10;
      MODE_IDX:        flags = 2'b10;
      MODE_DIST:       flags = 2'b01;
      MODE_INTERLEAVE: flags = 2'b11;
      default:         flags = 2'b10;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/best_array_streamer_if.sv
// Memory read port and output FIFO push port of the best-array streamer.
// master = streamer side, slave = memory/FIFO side.
interface best_array_streamer_if #(
  parameter int DATA_WIDTH = 11,
  parameter int DIST_WORDS = 2,
  parameter int ADDR_WIDTH = 9
);
  import ann_pkg::*;

  logic                             mem_ren;
  logic [ADDR_WIDTH-1:0]            mem_raddr;
  logic [DATA_WIDTH-1:0]            mem_ridx;
  logic [DIST_WORDS*DATA_WIDTH-1:0] mem_rdist;
  logic                             out_fifo_wenq;
  logic [DATA_WIDTH-1:0]            out_fifo_wdata;
  logic                             out_fifo_wfull_n;

  modport master (
    output mem_ren, mem_raddr,
    input  mem_ridx, mem_rdist,
    output out_fifo_wenq, out_fifo_wdata,
    input  out_fifo_wfull_n
  );

  modport slave (
    input  mem_ren, mem_raddr,
    output mem_ridx, mem_rdist,
    input  out_fifo_wenq, out_fifo_wdata,
    output out_fifo_wfull_n
  );

endinterface

// File: rtl/best_array_streamer_addr_gen.sv
// Blocked px/x/y/xi traversal counters. The address is kept in a register and
// moved by a constant stride chosen by which counter rolls over, so the
// address path is a single adder.
module blocked_addr_gen #(
  parameter int ROW_SIZE   = 32,
  parameter int COL_SIZE   = 16,
  parameter int NUM_PX     = 2,
  parameter int BLOCKING   = 4,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);
  import ann_pkg::*;

  localparam int X_NUM = ROW_SIZE / NUM_PX / BLOCKING;
  localparam int XIW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
  localparam int YW    = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int XW    = (X_NUM > 1)    ? $clog2(X_NUM)    : 1;
  localparam int PXW   = (NUM_PX > 1)   ? $clog2(NUM_PX)   : 1;

  // Address deltas when the named counter steps and all inner ones wrap to 0.
  localparam logic [ADDR_WIDTH-1:0] D_XI = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] D_Y  = ADDR_WIDTH'(ROW_SIZE - (BLOCKING - 1));
  localparam logic [ADDR_WIDTH-1:0] D_X  = ADDR_WIDTH'(BLOCKING - (BLOCKING - 1)
                                                       - (COL_SIZE - 1) * ROW_SIZE);
  localparam logic [ADDR_WIDTH-1:0] D_PX = ADDR_WIDTH'(ROW_SIZE / NUM_PX
                                                       - (X_NUM - 1) * BLOCKING
                                                       - (COL_SIZE - 1) * ROW_SIZE
                                                       - (BLOCKING - 1));

  logic [XIW-1:0]        r_xi;
  logic [YW-1:0]         r_y;
  logic [XW-1:0]         r_x;
  logic [PXW-1:0]        r_px;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_xi_end;
  logic                  w_y_end;
  logic                  w_x_end;
  logic                  w_px_end;

  assign w_xi_end = (r_xi == XIW'(BLOCKING - 1));
  assign w_y_end  = (r_y  == YW'(COL_SIZE - 1));
  assign w_x_end  = (r_x  == XW'(X_NUM - 1));
  assign w_px_end = (r_px == PXW'(NUM_PX - 1));
  assign o_last   = w_xi_end & w_y_end & w_x_end & w_px_end;
  assign o_addr   = r_addr;

  // Step the innermost counter; on wrap, carry outward and apply that stride.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_xi   <= '0;
      r_y    <= '0;
      r_x    <= '0;
      r_px   <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_xi   <= '0;
      r_y    <= '0;
      r_x    <= '0;
      r_px   <= '0;
      r_addr <= '0;
    end else if (i_step) begin
      if (!w_xi_end) begin
        r_xi   <= r_xi + XIW'(1);
        r_addr <= r_addr + D_XI;
      end else if (!w_y_end) begin
        r_xi   <= '0;
        r_y    <= r_y + YW'(1);
        r_addr <= r_addr + D_Y;
      end else if (!w_x_end) begin
        r_xi   <= '0;
        r_y    <= '0;
        r_x    <= r_x + XW'(1);
        r_addr <= r_addr + D_X;
      end else if (!w_px_end) begin
        r_xi   <= '0;
        r_y    <= '0;
        r_x    <= '0;
        r_px   <= r_px + PXW'(1);
        r_addr <= r_addr + D_PX;
      end else begin
        // Last entry of the pass: everything wraps back to address 0.
        r_xi   <= '0;
        r_y    <= '0;
        r_x    <= '0;
        r_px   <= '0;
        r_addr <= '0;
      end
    end
  end

endmodule

// File: rtl/best_array_streamer.sv
// Host-side output streamer: on a start pulse walks the best-match arrays in
// blocked order, reads index/distance per entry and pushes DATA_WIDTH-bit
// words into the output FIFO according to the selected stream mode.
module best_array_streamer #(
  parameter int DATA_WIDTH = ann_pkg::DATA_WIDTH,
  parameter int DIST_WORDS = 2,
  parameter int ROW_SIZE   = 32,
  parameter int COL_SIZE   = 16,
  parameter int NUM_PX     = 2,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS),
  parameter int WS_WIDTH   = $clog2(NUM_QUERYS * (1 + DIST_WORDS) + 1)
) (
  input  logic                  io_clk,
  input  logic                  io_rst_n,
  input  logic                  send_best_arr,
  input  logic [1:0]            mode,
  best_array_streamer_if.master bus,
  output logic                  busy,
  output logic                  send_done,
  output logic [WS_WIDTH-1:0]   words_sent
);
  import ann_pkg::*;

  localparam int WCW = $clog2(DIST_WORDS + 2);

  localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
  localparam logic [2:0] S_READ = 3'(ST_READ);
  localparam logic [2:0] S_CAPT = 3'(ST_CAPT);
  localparam logic [2:0] S_PUSH = 3'(ST_PUSH);
  localparam logic [2:0] S_DONE = 3'(ST_DONE);

  logic [2:0]                       r_state;
  logic [2:0]                       w_next_state;
  stream_mode_e                     r_mode;
  logic                             r_pass2;
  logic                             r_send_idx;
  logic                             r_send_dist;
  logic                             r_mem_ren;
  logic                             r_push_valid;
  logic                             r_busy;
  logic                             r_send_done;
  logic [DIST_WORDS*DATA_WIDTH-1:0] r_hold_dist;
  logic [WCW-1:0]                   r_word_cnt;
  logic [WCW-1:0]                   w_entry_words;
  logic [WCW-1:0]                   w_next_k;
  logic [DATA_WIDTH-1:0]            r_wdata;
  logic [DATA_WIDTH-1:0]            w_first_word;
  logic [DATA_WIDTH-1:0]            w_next_word;
  logic [WS_WIDTH-1:0]              r_words_sent;
  logic [ADDR_WIDTH-1:0]            w_addr;
  logic                             w_addr_last;
  logic                             w_start;
  logic                             w_push;
  logic                             w_last_word;
  logic                             w_step;
  logic                             w_more_pass;

  blocked_addr_gen #(
    .ROW_SIZE   (ROW_SIZE),
    .COL_SIZE   (COL_SIZE),
    .NUM_PX     (NUM_PX),
    .BLOCKING   (BLOCKING),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_clk   (io_clk),
    .i_rst_n (io_rst_n),
    .i_clr   (w_start),
    .i_step  (w_step),
    .o_addr  (w_addr),
    .o_last  (w_addr_last)
  );

  // Start is honoured only from IDLE, so pulses while busy fall through.
  assign w_start = (r_state == S_IDLE) & send_best_arr;

  // The word and its valid are registered; the enable is the valid masked by
  // the live not-full so a push never lands on a full FIFO and a stalled word
  // simply stays presented.
  assign w_push      = r_push_valid & bus.out_fifo_wfull_n;
  assign w_entry_words = (r_send_idx  ? WCW'(1)          : WCW'(0))
                       + (r_send_dist ? WCW'(DIST_WORDS) : WCW'(0));
  assign w_last_word = (r_word_cnt == (w_entry_words - WCW'(1)));
  assign w_step      = w_push & w_last_word;
  assign w_more_pass = (r_mode == MODE_SPLIT) & ~r_pass2;

  // Index is always word 0 of an entry, so it goes straight into the output
  // word register; only the distance needs holding for later words.
  assign w_first_word = r_send_idx ? bus.mem_ridx : bus.mem_rdist[DATA_WIDTH-1:0];
  assign w_next_k     = r_send_idx ? r_word_cnt : (r_word_cnt + WCW'(1));

  // Select the distance word that follows the one currently presented.
  always_comb begin
    w_next_word = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < DIST_WORDS; k++) begin
      if (w_next_k == WCW'(k)) begin
        w_next_word = r_hold_dist[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_next_word = w_next_word;
      end
    end
  end

  // Next-state decode of the stream FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (send_best_arr) w_next_state = S_READ;
        else               w_next_state = S_IDLE;
      end
      S_READ: w_next_state = S_CAPT;
      S_CAPT: w_next_state = S_PUSH;
      S_PUSH: begin
        if (w_step) begin
          if (!w_addr_last || w_more_pass) w_next_state = S_READ;
          else                             w_next_state = S_DONE;
        end else begin
          w_next_state = S_PUSH;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register and all registered datapath/status outputs.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_SPLIT;
      r_pass2      <= 1'b0;
      r_send_idx   <= 1'b0;
      r_send_dist  <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_push_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_send_done  <= 1'b0;
      r_hold_dist  <= '0;
      r_word_cnt   <= '0;
      r_wdata      <= '0;
      r_words_sent <= '0;
    end else begin
      r_state   <= w_next_state;
      r_mem_ren <= (w_next_state == S_READ);
      case (r_state)
        S_IDLE: begin
          if (send_best_arr) begin
            r_mode                    <= stream_mode_e'(mode);
            {r_send_idx, r_send_dist} <= pass_flags(stream_mode_e'(mode), 1'b0);
            r_pass2                   <= 1'b0;
            r_busy                    <= 1'b1;
            r_send_done               <= 1'b0;
            r_words_sent              <= '0;
          end
        end
        S_CAPT: begin
          r_hold_dist  <= bus.mem_rdist;
          r_word_cnt   <= '0;
          r_wdata      <= w_first_word;
          r_push_valid <= 1'b1;
        end
        S_PUSH: begin
          if (w_push) begin
            r_words_sent <= r_words_sent + WS_WIDTH'(1);
            r_word_cnt   <= r_word_cnt + WCW'(1);
            if (w_last_word) begin
              r_push_valid <= 1'b0;
              if (w_addr_last) begin
                if (w_more_pass) begin
                  r_pass2                   <= 1'b1;
                  {r_send_idx, r_send_dist} <= pass_flags(r_mode, 1'b1);
                end else begin
                  r_busy      <= 1'b0;
                  r_send_done <= 1'b1;
                end
              end
            end else begin
              r_wdata <= w_next_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_ren        = r_mem_ren;
  assign bus.mem_raddr      = w_addr;
  assign bus.out_fifo_wenq  = w_push;
  assign bus.out_fifo_wdata = r_wdata;
  assign busy               = r_busy;
  assign send_done          = r_send_done;
  assign words_sent         = r_words_sent;

endmodule

// File: tb/tb_best_array_streamer.sv
// Directed bench for best_array_streamer: a small 8x2 configuration for the
// mode/backpressure/reset cases and the default configuration for a full run.
module tb_best_array_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s_send, b_send;
  logic [1:0] s_mode, b_mode;
  logic       s_busy, s_done, b_busy, b_done;
  logic [5:0] s_ws;
  logic [10:0] b_ws;

  best_array_streamer_if #(.DATA_WIDTH(11), .DIST_WORDS(2), .ADDR_WIDTH(4)) s_bus ();
  best_array_streamer_if #(.DATA_WIDTH(11), .DIST_WORDS(2), .ADDR_WIDTH(9)) b_bus ();

  best_array_streamer #(
    .DATA_WIDTH(11), .DIST_WORDS(2), .ROW_SIZE(8), .COL_SIZE(2), .NUM_PX(2), .BLOCKING(2)
  ) u_small (
    .io_clk(clk), .io_rst_n(rst_n), .send_best_arr(s_send), .mode(s_mode), .bus(s_bus),
    .busy(s_busy), .send_done(s_done), .words_sent(s_ws)
  );

  best_array_streamer u_big (
    .io_clk(clk), .io_rst_n(rst_n), .send_best_arr(b_send), .mode(b_mode), .bus(b_bus),
    .busy(b_busy), .send_done(b_done), .words_sent(b_ws)
  );

  // Best-array memories: idx[a]=a, dist[a]={a, a+100}, one-cycle read latency.
  always @(posedge clk) begin
    if (s_bus.mem_ren) begin
      s_bus.mem_ridx  <= 11'(s_bus.mem_raddr);
      s_bus.mem_rdist <= {11'(s_bus.mem_raddr), 11'(s_bus.mem_raddr) + 11'd100};
    end
    if (b_bus.mem_ren) begin
      b_bus.mem_ridx  <= 11'(b_bus.mem_raddr);
      b_bus.mem_rdist <= {11'(b_bus.mem_raddr), 11'(b_bus.mem_raddr) + 11'd100};
    end
  end

  logic [10:0] s_q[$];
  logic [10:0] b_q[$];
  logic [10:0] exp_q[$];
  int          s_viol = 0;

  // Output FIFOs: capture every pushed word.
  always @(posedge clk) begin
    if (s_bus.out_fifo_wenq) s_q.push_back(s_bus.out_fifo_wdata);
    if (b_bus.out_fifo_wenq) b_q.push_back(b_bus.out_fifo_wdata);
  end

  // Push attempted against a full FIFO.
  always @(negedge clk) begin
    if (s_bus.out_fifo_wenq && !s_bus.out_fifo_wfull_n) s_viol++;
  end

  int n_vec = 0;
  int n_fail = 0;
  int t1_exp[16] = '{0, 1, 8, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15};
  int t3_exp[6]  = '{0, 100, 0, 1, 101, 1};
  int t6_exp[8]  = '{0, 1, 2, 3, 32, 33, 34, 35};
  int saved_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_word(input bit big, input int i);
    if (big) return (i < b_q.size()) ? 32'(b_q[i]) : 32'hFFFF_FFFF;
    else     return (i < s_q.size()) ? 32'(s_q[i]) : 32'hFFFF_FFFF;
  endfunction

  // Reference stream from a direct walk of the blocked traversal order.
  task automatic build_exp(input int R, input int C, input int B, input int NP, input logic [1:0] m);
    int a_list[$];
    exp_q.delete();
    for (int px = 0; px < NP; px++)
      for (int x = 0; x < R / NP / B; x++)
        for (int y = 0; y < C; y++)
          for (int xi = 0; xi < B; xi++)
            a_list.push_back(px * (R / NP) + y * R + x * B + xi);
    if (m == 2'b00 || m == 2'b01)
      foreach (a_list[i]) exp_q.push_back(11'(a_list[i]));
    if (m == 2'b00 || m == 2'b10)
      foreach (a_list[i]) begin
        exp_q.push_back(11'(a_list[i] + 100));
        exp_q.push_back(11'(a_list[i]));
      end
    if (m == 2'b11)
      foreach (a_list[i]) begin
        exp_q.push_back(11'(a_list[i]));
        exp_q.push_back(11'(a_list[i] + 100));
        exp_q.push_back(11'(a_list[i]));
      end
  endtask

  task automatic compare(input bit big, input string tag);
    int n;
    n = big ? b_q.size() : s_q.size();
    check($sformatf("%s_len", tag), 32'(n), 32'(exp_q.size()));
    foreach (exp_q[i]) check($sformatf("%s[%0d]", tag, i), get_word(big, i), 32'(exp_q[i]));
  endtask

  task automatic start_small(input logic [1:0] m);
    repeat (2) @(negedge clk);
    s_mode = m;
    s_send = 1'b1;
    @(negedge clk);
    s_send = 1'b0;
    s_mode = ~m;
  endtask

  task automatic wait_done(input bit big, input bit rand_bp, input int budget);
    int cyc = 0;
    while (!(big ? b_done : s_done) && cyc < budget) begin
      @(posedge clk);
      #1;
      if (rand_bp) s_bus.out_fifo_wfull_n = 1'($urandom_range(0, 1));
      cyc++;
    end
    check(big ? "big_done_wait" : "small_done_wait", 32'(big ? b_done : s_done), 32'd1);
    s_bus.out_fifo_wfull_n = 1'b1;
  endtask

  task automatic wait_qsize(input int n, input int budget);
    int cyc = 0;
    while (s_q.size() < n && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("qsize_wait", 32'(s_q.size() >= n), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    s_send = 1'b0; s_mode = 2'b00;
    b_send = 1'b0; b_mode = 2'b00;
    s_bus.out_fifo_wfull_n = 1'b1;
    b_bus.out_fifo_wfull_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_done", 32'(s_done), 32'd0);
    check("rst_ws", 32'(s_ws), 32'd0);
    check("rst_wenq", 32'(s_bus.out_fifo_wenq), 32'd0);
    check("rst_ren", 32'(s_bus.mem_ren), 32'd0);
    check("rst_big_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;

    // 1: indices only
    s_q.delete();
    start_small(2'b01);
    check("t1_busy", 32'(s_busy), 32'd1);
    check("t1_ren", 32'(s_bus.mem_ren), 32'd1);
    check("t1_raddr", 32'(s_bus.mem_raddr), 32'd0);
    @(negedge clk);
    check("t1_ren_1cyc", 32'(s_bus.mem_ren), 32'd0);
    wait_done(1'b0, 1'b0, 2000);
    for (int i = 0; i < 16; i++) check($sformatf("t1_word%0d", i), get_word(1'b0, i), 32'(t1_exp[i]));
    build_exp(8, 2, 2, 2, 2'b01);
    compare(1'b0, "t1");
    check("t1_ws", 32'(s_ws), 32'd16);
    check("t1_busy_end", 32'(s_busy), 32'd0);

    // 2: split mode
    s_q.delete();
    start_small(2'b00);
    wait_done(1'b0, 1'b0, 2000);
    check("t2_w16", get_word(1'b0, 16), 32'd100);
    check("t2_w17", get_word(1'b0, 17), 32'd0);
    check("t2_w47", get_word(1'b0, 47), 32'd15);
    build_exp(8, 2, 2, 2, 2'b00);
    compare(1'b0, "t2");
    check("t2_ws", 32'(s_ws), 32'd48);

    // 3: interleaved
    s_q.delete();
    start_small(2'b11);
    wait_done(1'b0, 1'b0, 2000);
    for (int i = 0; i < 6; i++) check($sformatf("t3_word%0d", i), get_word(1'b0, i), 32'(t3_exp[i]));
    build_exp(8, 2, 2, 2, 2'b11);
    compare(1'b0, "t3");
    check("t3_ws", 32'(s_ws), 32'd48);

    // 4: backpressure, fixed stall mid-entry then random toggling
    s_q.delete();
    s_viol = 0;
    start_small(2'b11);
    wait_qsize(4, 500);
    s_bus.out_fifo_wfull_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_stall_hold", 32'(s_q.size()), 32'd4);
    wait_done(1'b0, 1'b1, 4000);
    compare(1'b0, "t4");
    check("t4_ws", 32'(s_ws), 32'd48);
    check("t4_no_push_full", 32'(s_viol), 32'd0);

    // 5a: start pulse while busy is ignored
    s_q.delete();
    start_small(2'b01);
    repeat (3) @(negedge clk);
    s_mode = 2'b10;
    s_send = 1'b1;
    @(negedge clk);
    s_send = 1'b0;
    wait_done(1'b0, 1'b0, 2000);
    build_exp(8, 2, 2, 2, 2'b01);
    compare(1'b0, "t5a");
    check("t5a_ws", 32'(s_ws), 32'd16);

    // 5b: reset mid-stream, then a clean restart
    s_q.delete();
    start_small(2'b11);
    wait_qsize(5, 500);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5b_wenq", 32'(s_bus.out_fifo_wenq), 32'd0);
    check("t5b_busy", 32'(s_busy), 32'd0);
    check("t5b_done", 32'(s_done), 32'd0);
    check("t5b_ws", 32'(s_ws), 32'd0);
    saved_n = s_q.size();
    repeat (3) @(negedge clk);
    check("t5b_no_more_push", 32'(s_q.size()), 32'(saved_n));
    rst_n = 1'b1;
    s_q.delete();
    start_small(2'b01);
    wait_done(1'b0, 1'b0, 2000);
    build_exp(8, 2, 2, 2, 2'b01);
    compare(1'b0, "t5c");
    check("t5c_ws", 32'(s_ws), 32'd16);

    // 6: default parameters, split mode
    b_q.delete();
    repeat (2) @(negedge clk);
    b_mode = 2'b00;
    b_send = 1'b1;
    @(negedge clk);
    b_send = 1'b0;
    wait_done(1'b1, 1'b0, 10000);
    check("t6_len_at_done", 32'(b_q.size()), 32'd1536);
    for (int i = 0; i < 8; i++) check($sformatf("t6_word%0d", i), get_word(1'b1, i), 32'(t6_exp[i]));
    build_exp(32, 16, 4, 2, 2'b00);
    compare(1'b1, "t6");
    check("t6_ws", 32'(b_ws), 32'd1536);
    check("t6_busy", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/best_array_streamer.md
Name: best_array_streamer

Overview:
Host-side output streamer for the ANN accelerator. On a `send_best_arr` pulse it walks the best-match arrays in blocked px/x/y/xi order, reads each entry's index and distance from the best-array memory, and pushes DATA_WIDTH-bit words into the output FIFO toward mprj_io. It is the parametrised successor of the fixed 32x16, 2-partition, blocking-4 sender, and adds a selectable stream mode and a word counter.

Parameters:
- DATA_WIDTH, 11: width of an output word and of the stored index.
- DIST_WORDS, 2: distance width is DIST_WORDS*DATA_WIDTH; that many words are sent per distance.
- ROW_SIZE, 32: query patches per image row.
- COL_SIZE, 16: image rows.
- NUM_PX, 2: column partitions; ROW_SIZE % (NUM_PX*BLOCKING) == 0.
- BLOCKING, 4: entries per block column.
- NUM_QUERYS, ROW_SIZE*COL_SIZE: number of array entries.
- ADDR_WIDTH, $clog2(NUM_QUERYS): memory address width.

Ports:
- io_clk, in, 1: clock.
- io_rst_n, in, 1: asynchronous active-low reset.
- send_best_arr, in, 1: start pulse.
- mode, in, 2: stream mode, sampled when start is accepted.
- mem_ren, out, 1: best-array read enable.
- mem_raddr, out, ADDR_WIDTH: read address.
- mem_ridx, in, DATA_WIDTH: index read data; valid 1 cycle after mem_ren.
- mem_rdist, in, DIST_WORDS*DATA_WIDTH: distance read data; same timing as mem_ridx.
- out_fifo_wenq, out, 1: FIFO push.
- out_fifo_wdata, out, DATA_WIDTH: pushed word.
- out_fifo_wfull_n, in, 1: FIFO not full.
- busy, out, 1: stream in progress.
- send_done, out, 1: stream complete (level).
- words_sent, out, $clog2(NUM_QUERYS*(1+DIST_WORDS)+1): words pushed in the current or last stream.

Behaviour:
- Reset: io_clk is the single clock; io_rst_n is asynchronous and active-low. All outputs are 0, FSM is in IDLE, counters are 0.
- Traversal order, outermost to innermost:
  - px in 0..NUM_PX-1
  - x in 0..ROW_SIZE/NUM_PX/BLOCKING-1
  - y in 0..COL_SIZE-1
  - xi in 0..BLOCKING-1
  - addr = px*(ROW_SIZE/NUM_PX) + y*ROW_SIZE + x*BLOCKING + xi
  - Use incrementing counters; no multiplier is required in the address path.
- Modes:
  - 00: pass 1 sends all indices; pass 2 sends all distances. This is the legacy order.
  - 01: indices only.
  - 10: distances only.
  - 11: interleaved, one pass; each entry sends its index, then its distance words.
  - Distance words go out least-significant first: word k = rdist[k*DATA_WIDTH +: DATA_WIDTH].
- FSM states:
  - IDLE: on send_best_arr=1, latch mode, clear send_done and words_sent, reset counters, go to READ. busy=1 from the next cycle.
  - READ: drive mem_ren=1 with mem_raddr for exactly 1 cycle, then go to CAPT.
  - CAPT: latch mem_ridx and mem_rdist into holding registers, set word_cnt=0, go to PUSH.
  - PUSH: when out_fifo_wfull_n=1, assert wenq with the current word and increment words_sent and word_cnt. When wfull_n=0, wenq=0 and the word holds (no loss, no duplication). After the last word of the entry, advance counters and go to READ, or to the next pass (mode 00), or to DONE.
  - DONE: send_done=1, busy=0, return to IDLE. send_done stays high until the next accepted start.
- Minimum cost per entry is 2 + words cycles (index word = 1 word, distance = DIST_WORDS words).
- out_fifo_wenq is registered and never asserted while out_fifo_wfull_n=0 in the same cycle.
- send_best_arr while busy is ignored; mode changes mid-stream are ignored.
- Reset mid-stream aborts immediately: no further wenq, send_done=0.
- Last entry of a pass: the counters wrap to 0 for pass 2 of mode 00.
- Total words per stream:
  - mode 00 and 11: NUM_QUERYS*(1+DIST_WORDS)
  - mode 01: NUM_QUERYS
  - mode 10: NUM_QUERYS*DIST_WORDS

Decomposition:
- Package ann_pkg holds:
  - DATA_WIDTH
  - stream-mode enum (MODE_SPLIT, MODE_IDX, MODE_DIST, MODE_INTERLEAVE)
  - FSM state enum
- One sub-module, blocked_addr_gen:
  - px/x/y/xi counters with step/wrap/last outputs
  - produces addr by adding strides

Test Plan:
1. ROW_SIZE=8, COL_SIZE=2, BLOCKING=2, NUM_PX=2, mode 01, memory idx[a]=a, FIFO never full -> words are 0,1,8,9,2,3,10,11,4,5,12,13,6,7,14,15; send_done=1; words_sent=16.
2. Same config, mode 00, rdist[a]=(a<<11)|(a+100) -> 48 words: the 16 indices in order, then for each entry in the same order (a+100, a); words_sent=48.
3. Mode 11, same config -> per entry a: a, a+100, a; first 6 words are 0,100,0,1,101,1.
4. Backpressure: drop wfull_n for 5 cycles mid-entry, plus random 50% toggling for the whole stream -> sequence is identical to the no-stall run, and wenq is never high while wfull_n is low.
5. Pulse send_best_arr again while busy -> ignored, single stream; assert io_rst_n=0 mid-stream -> wenq=0, busy=0, send_done=0 immediately; a new start then produces the full stream from addr 0.
6. Default parameters, mode 00, idx[a]=a -> 1536 words; first index words are 0,1,2,3,32,33,34,35; send_done asserts after the last word.
